// File: rtl/neo_pkg.sv
// Shared definitions for the NEO-PVC P2 ROM read path.
package neo_pkg;

  localparam int P2_AW         = 24;
  localparam int P2_LINE_BYTES = 8;
  localparam int P2_LINE_W     = P2_LINE_BYTES * 8;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL} p2_state_t;

  // Select 16-bit word k of a 64-bit line, where k is byte address bits [2:1].
  function automatic logic [15:0] line_word(input logic [P2_LINE_W-1:0] line,
                                            input logic [1:0] sel);
    logic [15:0] w;
    case (sel)
      2'd0:    w = line[15:0];
      2'd1:    w = line[31:16];
      2'd2:    w = line[47:32];
      default: w = line[63:48];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/neo_p2_line_store.sv
// Direct-mapped line storage: data and tag arrays with asynchronous read,
// plus a valid vector that FLUSH clears in one clock.
module neo_p2_line_store
  import neo_pkg::*;
#(
  parameter int LINE_BITS = 4,
  parameter int TAG_W     = 17
) (
  input  logic                 CLK_48M,
  input  logic                 nRESET,
  input  logic [LINE_BITS-1:0] rd_index,
  output logic [P2_LINE_W-1:0] rd_data,
  output logic [TAG_W-1:0]     rd_tag,
  output logic                 rd_valid,
  input  logic                 wr_en,
  input  logic [LINE_BITS-1:0] wr_index,
  input  logic [P2_LINE_W-1:0] wr_data,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic                 clear_all
);

  localparam int LINES = 1 << LINE_BITS;

  logic [P2_LINE_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [LINES-1:0]     valid;

  always_ff @(posedge CLK_48M) begin
    if (wr_en) begin
      data_mem[wr_index] <= wr_data;
      tag_mem[wr_index]  <= wr_tag;
    end
  end

  // Clear-all wins over a same-cycle write so a fill racing a flush stays invalid.
  always_ff @(posedge CLK_48M or negedge nRESET) begin
    if (!nRESET)
      valid <= '0;
    else if (clear_all)
      valid <= '0;
    else if (wr_en)
      valid[wr_index] <= 1'b1;
  end

  assign rd_data  = data_mem[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid[rd_index];

endmodule

// File: rtl/neo_p2_cache.sv
// Read cache between neo_pvc's banked P2 address and the SDRAM controller:
// strobe detect, lookup/fill FSM, SDRAM handshake and saturating miss counter.
module neo_p2_cache
  import neo_pkg::*;
#(
  parameter int LINE_BITS = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 CLK_48M,
  input  logic                 nRESET,
  input  logic [P2_AW-1:0]     P2_ADDR,
  input  logic                 nROMOE,
  input  logic                 FLUSH,
  output logic [15:0]          PROM_DATA,
  output logic                 nROMWAIT,
  output logic                 SDR_REQ,
  output logic [P2_AW-1:0]     SDR_ADDR,
  input  logic                 SDR_ACK,
  input  logic [P2_LINE_W-1:0] SDR_DATA,
  output logic [CNT_W-1:0]     STAT_MISS
);

  localparam int TAG_W = P2_AW - 3 - LINE_BITS;

  p2_state_t            state;
  logic [P2_AW-1:1]     addr_q;
  logic                 nromoe_d;
  logic                 start;
  logic                 hit;
  logic                 fill_done;
  logic [LINE_BITS-1:0] line_index;
  logic [TAG_W-1:0]     line_tag;
  logic [P2_LINE_W-1:0] rd_data;
  logic [TAG_W-1:0]     rd_tag;
  logic                 rd_valid;
  logic                 unused_addr_bit;

  assign unused_addr_bit = P2_ADDR[0];
  assign start      = ~nROMOE & nromoe_d;
  assign line_index = addr_q[3+LINE_BITS-1:3];
  assign line_tag   = addr_q[P2_AW-1:3+LINE_BITS];
  // A flush landing on the lookup cycle must not let a stale line through.
  assign hit        = rd_valid & (rd_tag == line_tag) & ~FLUSH;
  assign fill_done  = (state == FILL) & SDR_ACK;

  neo_p2_line_store #(
    .LINE_BITS (LINE_BITS),
    .TAG_W     (TAG_W)
  ) u_store (
    .CLK_48M   (CLK_48M),
    .nRESET    (nRESET),
    .rd_index  (line_index),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_en     (fill_done),
    .wr_index  (line_index),
    .wr_data   (SDR_DATA),
    .wr_tag    (line_tag),
    .clear_all (FLUSH)
  );

  always_ff @(posedge CLK_48M or negedge nRESET) begin
    if (!nRESET) begin
      state     <= IDLE;
      addr_q    <= '0;
      nromoe_d  <= 1'b1;
      PROM_DATA <= '0;
      nROMWAIT  <= 1'b1;
      SDR_REQ   <= 1'b0;
      SDR_ADDR  <= '0;
      STAT_MISS <= '0;
    end else begin
      nromoe_d <= nROMOE;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q   <= P2_ADDR[P2_AW-1:1];
            nROMWAIT <= 1'b0;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            PROM_DATA <= line_word(rd_data, addr_q[2:1]);
            nROMWAIT  <= 1'b1;
            state     <= IDLE;
          end else begin
            SDR_ADDR <= {addr_q[P2_AW-1:3], 3'b000};
            SDR_REQ  <= 1'b1;
            if (STAT_MISS != '1)
              STAT_MISS <= STAT_MISS + 1'b1;
            state <= FILL;
          end
        end
        FILL: begin
          // The 68k may drop its strobe here; the fill completes regardless.
          if (SDR_ACK) begin
            PROM_DATA <= line_word(SDR_DATA, addr_q[2:1]);
            SDR_REQ   <= 1'b0;
            nROMWAIT  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neo_p2_cache.sv
// Directed plus randomized checks of neo_p2_cache against a line-level cache model.
module tb_neo_p2_cache;

  logic        CLK_48M;
  logic        nRESET;
  logic [23:0] P2_ADDR;
  logic        nROMOE;
  logic        FLUSH;
  logic [15:0] PROM_DATA;
  logic        nROMWAIT;
  logic        SDR_REQ;
  logic [23:0] SDR_ADDR;
  logic        SDR_ACK;
  logic [63:0] SDR_DATA;
  logic [15:0] STAT_MISS;

  int total = 0;
  int bad   = 0;

  // Model: which 21-bit line address each of the 16 slots holds, and the miss tally.
  logic [20:0] m_line  [16];
  bit          m_valid [16];
  int          m_miss;

  neo_p2_cache #(.LINE_BITS(4), .CNT_W(16)) dut (
    .CLK_48M   (CLK_48M),
    .nRESET    (nRESET),
    .P2_ADDR   (P2_ADDR),
    .nROMOE    (nROMOE),
    .FLUSH     (FLUSH),
    .PROM_DATA (PROM_DATA),
    .nROMWAIT  (nROMWAIT),
    .SDR_REQ   (SDR_REQ),
    .SDR_ADDR  (SDR_ADDR),
    .SDR_ACK   (SDR_ACK),
    .SDR_DATA  (SDR_DATA),
    .STAT_MISS (STAT_MISS)
  );

  initial CLK_48M = 1'b0;
  always #10 CLK_48M = ~CLK_48M;

  // SDRAM contents as a pure function of the line address.
  function automatic logic [63:0] mem_line(input logic [23:0] a);
    logic [20:0] la;
    la = a[23:3];
    if (la == 21'h020000) return 64'h4444_3333_2222_1111;
    return {16'(la * 7 + 3), 16'(la) ^ 16'hA5A5, 16'(la + 21'h1357), 16'(la)};
  endfunction

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    logic [63:0] l;
    l = mem_line(a);
    return 16'(l >> (16 * int'(a[2:1])));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One 68k read: strobe, answer any SDRAM request after ack_delay clocks,
  // optionally flush on the lookup or ack cycle, optionally drop nROMOE mid-fill.
  task automatic applyStimulus(input logic [23:0] addr, input int ack_delay,
                               input bit flush_lookup, input bit flush_ack,
                               input bit raise_mid);
    bit          exp_hit, saw_low, released, req_seen;
    int          idx, cycles, req_cycles;
    logic [23:0] req_addr;

    idx = int'(addr[6:3]);
    if (flush_lookup) model_clear();
    exp_hit = m_valid[idx] && (m_line[idx] == addr[23:3]);
    if (!exp_hit) begin
      m_miss++;
      if (!flush_ack) begin
        m_valid[idx] = 1;
        m_line[idx]  = addr[23:3];
      end else
        model_clear();
    end

    @(posedge CLK_48M); #1;
    P2_ADDR = addr;
    nROMOE  = 1'b0;
    saw_low = 0; released = 0; req_seen = 0;
    cycles = 0; req_cycles = 0; req_addr = '0;
    for (int c = 0; c < 200 && !released; c++) begin
      @(negedge CLK_48M);
      SDR_ACK = 1'b0;
      FLUSH   = 1'b0;
      cycles++;
      if (!nROMWAIT) begin
        if (!saw_low && flush_lookup) FLUSH = 1'b1;
        saw_low = 1;
      end else if (saw_low)
        released = 1;
      if (SDR_REQ && !released) begin
        if (!req_seen) req_addr = SDR_ADDR;
        req_seen = 1;
        if (raise_mid && req_cycles == 0) nROMOE = 1'b1;
        if (req_cycles == ack_delay) begin
          SDR_ACK  = 1'b1;
          SDR_DATA = mem_line(addr);
          if (flush_ack) FLUSH = 1'b1;
        end
        req_cycles++;
      end
    end
    SDR_ACK = 1'b0;
    FLUSH   = 1'b0;

    checkOutput("released", 64'(released), 64'd1);
    checkOutput("prom_data", 64'(PROM_DATA), 64'(mem_word(addr)));
    checkOutput("req_seen", 64'(req_seen), 64'(!exp_hit));
    checkOutput("stat_miss", 64'(STAT_MISS), 64'(m_miss));
    if (exp_hit)
      checkOutput("hit_hold_clocks", 64'(cycles - 1), 64'd2);
    else begin
      checkOutput("miss_hold_clocks", 64'(cycles - 1), 64'(3 + ack_delay));
      checkOutput("sdr_addr", 64'(req_addr), 64'({addr[23:3], 3'b000}));
    end
    checkOutput("req_idle", 64'(SDR_REQ), 64'd0);

    @(posedge CLK_48M); #1;
    nROMOE = 1'b1;
  endtask

  task automatic flush_pulse();
    @(posedge CLK_48M); #1;
    FLUSH = 1'b1;
    @(posedge CLK_48M); #1;
    FLUSH = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [23:0] ra;
    nRESET   = 1'b0;
    P2_ADDR  = '0;
    nROMOE   = 1'b1;
    FLUSH    = 1'b0;
    SDR_ACK  = 1'b0;
    SDR_DATA = '0;
    m_miss   = 0;
    model_clear();
    repeat (3) @(posedge CLK_48M);
    #1;
    checkOutput("rst_prom_data", 64'(PROM_DATA), 64'd0);
    checkOutput("rst_nromwait", 64'(nROMWAIT), 64'd1);
    checkOutput("rst_sdr_req", 64'(SDR_REQ), 64'd0);
    checkOutput("rst_sdr_addr", 64'(SDR_ADDR), 64'd0);
    checkOutput("rst_stat_miss", 64'(STAT_MISS), 64'd0);
    nRESET = 1'b1;
    repeat (2) @(posedge CLK_48M);

    $display("[TB] cold miss, hit, conflict");
    applyStimulus(24'h100002, 5, 0, 0, 0);
    checkOutput("cold_word", 64'(PROM_DATA), 64'h2222);
    applyStimulus(24'h100006, 0, 0, 0, 0);
    checkOutput("hit_word", 64'(PROM_DATA), 64'h4444);
    applyStimulus(24'h100080, 2, 0, 0, 0);
    applyStimulus(24'h100000, 1, 0, 0, 0);
    checkOutput("conflict_misses", 64'(STAT_MISS), 64'd3);

    $display("[TB] flush handling");
    flush_pulse();
    applyStimulus(24'h100000, 3, 0, 1, 0);
    applyStimulus(24'h100004, 0, 0, 0, 0);
    applyStimulus(24'h100004, 0, 1, 0, 0);

    $display("[TB] strobe dropped mid-fill");
    applyStimulus(24'h100040, 4, 0, 0, 1);
    applyStimulus(24'h100042, 0, 0, 0, 0);

    $display("[TB] randomized reads");
    for (int n = 0; n < 60; n++) begin
      ra = 24'h100000 + 24'($urandom_range(0, 3) << 7) + 24'($urandom_range(0, 15) << 3)
           + 24'($urandom_range(0, 3) << 1);
      applyStimulus(ra, int'($urandom_range(0, 4)), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] reset during fill");
    @(posedge CLK_48M); #1;
    P2_ADDR = 24'h1000C8;
    nROMOE  = 1'b0;
    repeat (4) @(negedge CLK_48M);
    checkOutput("pre_reset_req", 64'(SDR_REQ), 64'd1);
    nRESET = 1'b0;
    #1;
    checkOutput("reset_req_drop", 64'(SDR_REQ), 64'd0);
    checkOutput("reset_wait_high", 64'(nROMWAIT), 64'd1);
    checkOutput("reset_miss_clr", 64'(STAT_MISS), 64'd0);
    nROMOE = 1'b1;
    @(posedge CLK_48M); #1;
    nRESET = 1'b1;
    m_miss = 0;
    model_clear();
    @(negedge CLK_48M);
    SDR_ACK  = 1'b1;
    SDR_DATA = 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge CLK_48M);
    SDR_ACK = 1'b0;
    checkOutput("stray_ack_wait", 64'(nROMWAIT), 64'd1);
    checkOutput("stray_ack_data", 64'(PROM_DATA), 64'd0);
    applyStimulus(24'h100002, 1, 0, 0, 0);
    applyStimulus(24'h100042, 0, 0, 0, 0);
    applyStimulus(24'h1000C8, 2, 0, 0, 0);
    checkOutput("post_reset_misses", 64'(STAT_MISS), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
